// File: rtl/tank_pkg.sv
// tank_pkg: shared types and constants for the tank level controller.
//   state_t  - refill state machine encoding (IDLE / REFILL / FAULT)
//   ERR_OVF  - err_code bit recording an overflow (clamped at MAX_LEVEL)
//   ERR_UDF  - err_code bit recording an underflow (clamped at 0)
package tank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

endpackage

// File: rtl/tank_sat_accum.sv
// tank_sat_accum: saturating level register.
//   Each clock edge the level moves by (+FILL_STEP if fill) - (CONSUME_STEP if
//   consume). The result is clamped to [0, MAX_LEVEL].
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (level -> 0)
//   fill      - add FILL_STEP this cycle
//   consume   - remove CONSUME_STEP this cycle
//   level     - registered level
//   ovf, udf  - combinational strobes: the update applied at the coming edge
//               clamps high (ovf) or low (udf)
module tank_sat_accum #(
    parameter int WIDTH        = 8,
    parameter int MAX_LEVEL    = 200,
    parameter int FILL_STEP    = 3,
    parameter int CONSUME_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic             consume,
    output logic [WIDTH-1:0] level,
    output logic             ovf,
    output logic             udf
);

    // Two extra bits: one for the sign, one so level + FILL_STEP cannot wrap.
    localparam int SW = WIDTH + 2;

    localparam logic signed [SW-1:0] FILL_S    = SW'(FILL_STEP);
    localparam logic signed [SW-1:0] CONSUME_S = SW'(CONSUME_STEP);
    localparam logic signed [SW-1:0] MAX_S     = SW'(MAX_LEVEL);
    localparam logic [WIDTH-1:0]     MAX_L     = WIDTH'(MAX_LEVEL);

    logic signed [SW-1:0] net;
    logic signed [SW-1:0] sum;
    logic [WIDTH-1:0]     level_next;

    always_comb begin
        net = '0;
        if (fill) begin
            net = net + FILL_S;
        end
        if (consume) begin
            net = net - CONSUME_S;
        end
        sum = $signed({2'b00, level}) + net;
        ovf = (sum > MAX_S);
        udf = sum[SW-1];
        if (ovf) begin
            level_next = MAX_L;
        end else if (udf) begin
            level_next = '0;
        end else begin
            level_next = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= level_next;
        end
    end

endmodule

// File: rtl/tank_level_ctrl.sv
// tank_level_ctrl: tank level tracker with sticky errors and refill pump FSM.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   fill       - add FILL_STEP this cycle
//   consume    - remove CONSUME_STEP this cycle
//   clr_err    - clear sticky errors and leave FAULT
//   auto_en    - enable automatic refill
//   height     - registered level
//   empty/full - height == 0 / height == MAX_LEVEL
//   error      - registered OR of err_code
//   err_code   - sticky {underflow, overflow}
//   pump       - registered refill request, high only in REFILL
//   fsm_state  - current FSM state (debug observation)
//
// Interface note: fill/consume/clr_err/auto_en are level-sampled commands, one
// action per clock edge; there is no valid/ready handshake on this block.
module tank_level_ctrl
    import tank_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MAX_LEVEL    = 200,
    parameter int FILL_STEP    = 3,
    parameter int CONSUME_STEP = 2,
    parameter int LOW_MARK     = 10,
    parameter int HIGH_MARK    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic             consume,
    input  logic             clr_err,
    input  logic             auto_en,
    output logic [WIDTH-1:0] height,
    output logic             empty,
    output logic             full,
    output logic             error,
    output logic [1:0]       err_code,
    output logic             pump,
    output logic [1:0]       fsm_state
);

    // Parameter legality, rejected at elaboration.
    if (MAX_LEVEL >= (1 << WIDTH)) begin : g_bad_max
        $error("tank_level_ctrl: MAX_LEVEL must be below 2**WIDTH");
    end
    if (FILL_STEP < 1 || CONSUME_STEP < 1) begin : g_bad_step
        $error("tank_level_ctrl: FILL_STEP and CONSUME_STEP must be >= 1");
    end
    if (LOW_MARK >= HIGH_MARK) begin : g_bad_low
        $error("tank_level_ctrl: LOW_MARK must be below HIGH_MARK");
    end
    if (HIGH_MARK > MAX_LEVEL) begin : g_bad_high
        $error("tank_level_ctrl: HIGH_MARK must not exceed MAX_LEVEL");
    end

    localparam logic [WIDTH-1:0] MAX_L  = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH-1:0] LOW_L  = WIDTH'(LOW_MARK);
    localparam logic [WIDTH-1:0] HIGH_L = WIDTH'(HIGH_MARK);

    logic       ovf;
    logic       udf;
    logic [1:0] err_next;
    logic       pump_next;
    state_t     state;
    state_t     state_next;

    tank_sat_accum #(
        .WIDTH        (WIDTH),
        .MAX_LEVEL    (MAX_LEVEL),
        .FILL_STEP    (FILL_STEP),
        .CONSUME_STEP (CONSUME_STEP)
    ) u_accum (
        .clk     (clk),
        .rst     (rst),
        .fill    (fill),
        .consume (consume),
        .level   (height),
        .ovf     (ovf),
        .udf     (udf)
    );

    assign empty = (height == '0);
    assign full  = (height == MAX_L);

    // Clear first, then OR in this cycle's strobes: a fresh error beats clr_err.
    always_comb begin
        err_next = clr_err ? 2'b00 : err_code;
        if (ovf) begin
            err_next[ERR_OVF] = 1'b1;
        end
        if (udf) begin
            err_next[ERR_UDF] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_code <= 2'b00;
            error    <= 1'b0;
        end else begin
            err_code <= err_next;
            error    <= |err_next;
        end
    end

    // State register; pump is registered from the next-state decode so it
    // changes on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pump  <= 1'b0;
        end else begin
            state <= state_next;
            pump  <= pump_next;
        end
    end

    // Next-state logic works on registered height/error, so pump lags a
    // threshold crossing by one edge. FAULT is left only through clr_err with
    // no new error on that same edge.
    always_comb begin
        state_next = state;
        case (state)
            FAULT: begin
                if (clr_err && !ovf && !udf) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (error) begin
                    state_next = FAULT;
                end else if (auto_en && (height < LOW_L)) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                if (error) begin
                    state_next = FAULT;
                end else if (!auto_en || (height >= HIGH_L)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        pump_next = (state_next == REFILL);
        fsm_state = state;
    end

endmodule

// File: tb/tb_tank_level_ctrl.sv
module tb_tank_level_ctrl;

    localparam int WIDTH        = 8;
    localparam int MAX_LEVEL    = 200;
    localparam int FILL_STEP    = 3;
    localparam int CONSUME_STEP = 2;
    localparam int LOW_MARK     = 10;
    localparam int HIGH_MARK    = 20;

    localparam int S_IDLE   = 0;
    localparam int S_REFILL = 1;
    localparam int S_FAULT  = 2;

    logic             clk;
    logic             rst;
    logic             fill;
    logic             consume;
    logic             clr_err;
    logic             auto_en;
    logic [WIDTH-1:0] height;
    logic             empty;
    logic             full;
    logic             error;
    logic [1:0]       err_code;
    logic             pump;
    logic [1:0]       fsm_state;

    int checks = 0;
    int errors = 0;

    // Reference model state, written from the behavioural rules.
    int m_h;
    int m_err;
    int m_error;
    int m_st;

    tank_level_ctrl #(
        .WIDTH        (WIDTH),
        .MAX_LEVEL    (MAX_LEVEL),
        .FILL_STEP    (FILL_STEP),
        .CONSUME_STEP (CONSUME_STEP),
        .LOW_MARK     (LOW_MARK),
        .HIGH_MARK    (HIGH_MARK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fill      (fill),
        .consume   (consume),
        .clr_err   (clr_err),
        .auto_en   (auto_en),
        .height    (height),
        .empty     (empty),
        .full      (full),
        .error     (error),
        .err_code  (err_code),
        .pump      (pump),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h     = 0;
        m_err   = 0;
        m_error = 0;
        m_st    = S_IDLE;
    endtask

    task automatic model_step(input bit f, input bit c, input bit clr, input bit au);
        int  sum;
        bit  o;
        bit  u;
        int  h_old;
        int  e_old;
        h_old = m_h;
        e_old = m_error;
        sum = m_h + (f ? FILL_STEP : 0) - (c ? CONSUME_STEP : 0);
        o = (sum > MAX_LEVEL);
        u = (sum < 0);
        m_h = o ? MAX_LEVEL : (u ? 0 : sum);
        m_err = (clr ? 0 : m_err) | (o ? 1 : 0) | (u ? 2 : 0);
        m_error = (m_err != 0) ? 1 : 0;
        if (m_st == S_FAULT) begin
            if (clr && !o && !u) m_st = S_IDLE;
        end else if (e_old != 0) begin
            m_st = S_FAULT;
        end else if (m_st == S_IDLE) begin
            if (au && h_old < LOW_MARK) m_st = S_REFILL;
        end else begin
            if (!au || h_old >= HIGH_MARK) m_st = S_IDLE;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".height"},   32'(height),   32'(m_h));
        check({tag, ".empty"},    32'(empty),    32'(m_h == 0));
        check({tag, ".full"},     32'(full),     32'(m_h == MAX_LEVEL));
        check({tag, ".error"},    32'(error),    32'(m_error));
        check({tag, ".err_code"}, 32'(err_code), 32'(m_err));
        check({tag, ".pump"},     32'(pump),     32'(m_st == S_REFILL));
        check({tag, ".state"},    32'(fsm_state), 32'(m_st));
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit f, input bit c, input bit clr, input bit au, input string tag);
        fill    = f;
        consume = c;
        clr_err = clr;
        auto_en = au;
        @(posedge clk);
        model_step(f, c, clr, au);
        #1;
        check_all(tag);
    endtask

    task automatic sync_reset(input bit au);
        rst     = 1'b1;
        fill    = 1'b0;
        consume = 1'b0;
        clr_err = 1'b0;
        auto_en = au;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        fill    = 1'b0;
        consume = 1'b0;
        clr_err = 1'b0;
        auto_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        sync_reset(1'b0);
        check("reset_empty", 32'(empty), 32'd1);

        // Plain fills: 3, 6, 9, 12.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, "fill");
        check("fill4_height", 32'(height), 32'd12);

        // Fill and consume together: net +1 per cycle, 13..17.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, "fill_cons");
        check("net_height", 32'(height), 32'd17);

        // Overflow: climb to 199, then one more fill clamps at 200.
        while (m_h + FILL_STEP <= 199) step(1, 0, 0, 0, "climb");
        while (m_h < 199) step(1, 1, 0, 0, "climb_fine");
        check("pre_ovf_height", 32'(height), 32'd199);
        step(1, 0, 0, 0, "ovf");
        check("ovf_height", 32'(height), 32'd200);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_code", 32'(err_code), 32'd1);
        check("ovf_error", 32'(error), 32'd1);
        step(0, 0, 0, 0, "ovf_fault");
        check("ovf_fault_state", 32'(fsm_state), 32'(S_FAULT));
        check("ovf_fault_pump", 32'(pump), 32'd0);
        step(0, 0, 1, 0, "ovf_clr");
        check("ovf_clr_code", 32'(err_code), 32'd0);
        check("ovf_clr_state", 32'(fsm_state), 32'(S_IDLE));

        // Underflow: down to 1, then consume clamps at 0.
        while (m_h > 3) step(0, 1, 0, 0, "drain");
        while (m_h < 3) step(1, 1, 0, 0, "drain_fine");
        step(0, 1, 0, 0, "to_one");
        check("pre_udf_height", 32'(height), 32'd1);
        step(0, 1, 0, 0, "udf");
        check("udf_height", 32'(height), 32'd0);
        check("udf_code", 32'(err_code), 32'd2);
        step(0, 0, 0, 0, "udf_fault");
        step(0, 1, 1, 0, "udf_clr_collide");
        check("udf_collide_code", 32'(err_code), 32'd2);
        check("udf_collide_state", 32'(fsm_state), 32'(S_FAULT));
        step(0, 0, 1, 0, "udf_clr");
        check("udf_clr_state", 32'(fsm_state), 32'(S_IDLE));

        // Hysteresis with auto_en held from reset.
        sync_reset(1'b1);
        step(0, 0, 0, 1, "auto_start");
        check("pump_after_rst", 32'(pump), 32'd1);
        while (m_h < 21) step(1, 0, 0, 1, "auto_fill");
        check("pump_at_21", 32'(pump), 32'd1);
        step(0, 0, 0, 1, "auto_top");
        check("pump_drop", 32'(pump), 32'd0);
        while (m_h >= LOW_MARK) step(0, 1, 0, 1, "auto_drain");
        check("pump_below_low", 32'(pump), 32'd0);
        step(0, 0, 0, 1, "auto_low");
        check("pump_reassert", 32'(pump), 32'd1);
        while (m_h < 15) step(1, 0, 0, 1, "auto_refill");
        check("refill_height", 32'(height), 32'd15);

        // Asynchronous reset in the middle of a cycle, mid-REFILL.
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_height", 32'(height), 32'd0);
        check("arst_pump", 32'(pump), 32'd0);
        check("arst_error", 32'(error), 32'd0);
        check_all("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomised phases: fill-heavy and drain-heavy bursts.
        for (int blk = 0; blk < 10; blk++) begin
            int  bias;
            bit  au;
            bias = $urandom_range(0, 2);
            au   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 40; i++) begin
                bit f;
                bit c;
                bit clr;
                f   = ($urandom_range(0, 9) < (bias == 0 ? 9 : (bias == 1 ? 2 : 5)));
                c   = ($urandom_range(0, 9) < (bias == 1 ? 9 : (bias == 0 ? 2 : 5)));
                clr = ($urandom_range(0, 19) == 0);
                step(f, c, clr, au, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
